// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/dmem_strb_gen.sv
// Byte-lane strobe and alignment decode from access size and byte offset.
module dmem_strb_gen
  import dmem_pkg::*;
(
  input  logic [1:0] size_sel,
  input  logic [1:0] offset,
  output logic [3:0] bus_strb,
  output logic       misaligned
);

  always_comb begin
    bus_strb   = 4'b0000;
    misaligned = 1'b0;
    case (size_sel)
      SZ_BYTE: bus_strb = 4'b0001 << offset;
      SZ_HALF: begin
        bus_strb   = 4'b0011 << offset;
        misaligned = offset[0];
      end
      // size code 11 decodes as a word access
      default: begin
        bus_strb   = 4'b1111;
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the single-cycle core's data-memory port onto a valid/ready bus,
// stalling the core for the duration of each bus transaction.
module dmem_bus_bridge
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [1:0]            size_sel,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  bus_err,
  output logic                  bus_valid,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_strb,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t                  state_reg;
  logic [7:0]              cnt_reg;
  logic [1:0]              off_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    request;
  logic                    mis_cond;
  logic [3:0]              strb_calc;

  dmem_strb_gen u_strb_gen (
    .size_sel   (size_sel),
    .offset     (addr[1:0]),
    .bus_strb   (strb_calc),
    .misaligned (mis_cond)
  );

  assign request    = mem_read | mem_write;
  assign misaligned = request & mis_cond;
  // A dropped misaligned access retires with zero data without disturbing the held read value.
  assign rdata      = misaligned ? '0 : rdata_reg;

  always_comb begin
    stall = 1'b0;
    case (state_reg)
      IDLE:    stall = request & ~mis_cond;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      off_reg   <= '0;
      rdata_reg <= '0;
      bus_err   <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_strb  <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (request && !mis_cond) begin
            bus_valid <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            bus_wdata <= wdata;
            bus_strb  <= mem_write ? strb_calc : 4'b0000;
            off_reg   <= addr[1:0];
            cnt_reg   <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (!bus_we) rdata_reg <= bus_rdata >> {off_reg, 3'b000};
            state_reg <= DONE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            bus_valid <= 1'b0;
            rdata_reg <= '0;
            bus_err   <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the RV32I single-cycle datapath, between the core's data-memory port and a valid/ready data bus.
- Consumes the ALU address and the lane-replicated store data from the datapath.
- Returns the read data to the datapath's load logic, shifted so the addressed byte sits in bits [7:0].
- Holds the core with a stall signal for the length of each bus transaction, and flags misaligned accesses and bus timeouts.

Parameters:
- DATA_WIDTH, 32, width of the data word and of the bus data.
- ADDR_WIDTH, 32, width of the byte address.
- TIMEOUT_CYC, 255, number of BUSY cycles without bus_ready before the access is aborted. Counter width is 8 bits; legal values are 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  load request from the decoder.
- mem_write  in  1  store request from the decoder.
- addr  in  ADDR_WIDTH  byte address (the ALU result).
- wdata  in  DATA_WIDTH  store data, already replicated across byte lanes.
- size_sel  in  2  access size: 00 byte, 01 half, 10 word. 11 is treated as word.
- rdata  out  DATA_WIDTH  read word shifted right by 8*addr[1:0], to the load logic.
- stall  out  1  core must hold PC and the register-file write while this is 1.
- misaligned  out  1  current request is misaligned.
- bus_err  out  1  one-cycle pulse when an access times out.
- bus_valid  out  1  bus request valid.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_WIDTH  word-aligned address, addr with bits [1:0] = 00.
- bus_wdata  out  DATA_WIDTH  write data.
- bus_strb  out  4  byte-lane write strobes.
- bus_ready  in  1  slave accepts/completes the access this cycle.
- bus_rdata  in  DATA_WIDTH  read data, valid when bus_ready = 1.

Behaviour:
- Reset (asynchronous): state = IDLE, bus_valid = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, bus_strb = 0, rdata = 0, bus_err = 0, timeout counter = 0.
- Asserting rst mid-transaction drops bus_valid immediately, with no wait for the clock edge.
- Request = mem_read | mem_write. If both are high, mem_write has priority; the decoder must never produce this.
- Misaligned condition (combinational): half access with addr[0] = 1, or word access with addr[1:0] != 00.
  - misaligned = request & that condition.
  - A misaligned request issues no bus access, stall = 0, rdata = 0. The access is dropped (writes suppressed), and the instruction retires in one cycle.
- Strobes:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
  - Reads issue bus_strb = 0000.
- FSM states are IDLE, BUSY and DONE.
  - IDLE: stall = request & ~misaligned, combinational. On an aligned request, the clock edge registers bus_addr/bus_we/bus_wdata/bus_strb, sets bus_valid = 1, clears the counter, and moves to BUSY.
  - BUSY: stall = 1. bus_valid and the whole payload stay stable until bus_ready.
    - On bus_ready: bus_valid -> 0. For a read, rdata <= bus_rdata >> (8*addr_q[1:0]), where addr_q is the registered byte offset. Next state is DONE.
    - Otherwise the counter increments. When the counter == TIMEOUT_CYC-1 and bus_ready = 0, the access aborts: bus_valid -> 0, rdata <= 0, bus_err pulses for 1 cycle (registered), next state is DONE.
  - DONE: stall = 0 for exactly one cycle so the instruction retires, then IDLE unconditionally.
  - A request seen in DONE is not acted upon; it belongs to the retiring instruction.
- Latency:
  - Zero-wait slave (bus_ready high in the first BUSY cycle): 3 cycles per memory instruction, i.e. 2 stall cycles.
  - Each wait cycle adds one.
- rdata holds its value until the next completed read. Writes leave rdata unchanged.
- bus_ready while bus_valid = 0 is ignored.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2
  - the size codes SZ_BYTE/SZ_HALF/SZ_WORD
  - the default TIMEOUT_CYC
- One natural combinational sub-module, dmem_strb_gen: inputs size_sel and addr[1:0]; outputs bus_strb and misaligned.
- The FSM, counter and registers stay in dmem_bus_bridge.

Test Plan:
- Word read, addr = 0x0000_1004, size 10, bus_ready tied 1, bus_rdata = 0xDEAD_BEEF:
  - stall high for 2 cycles, bus_addr = 0x1004, strb = 0000
  - rdata = 0xDEAD_BEEF in the DONE cycle, retire on the 3rd cycle
- Byte store, addr = 0x2003, wdata = 0x5555_5555, bus_ready after 3 wait cycles:
  - bus_strb = 1000, bus_we = 1, payload stable through all waits
  - stall high for 5 cycles
- Half read, addr = 0x3002, bus_rdata = 0xABCD_1234 → rdata = 0x0000_ABCD.
- Misaligned word read at addr = 0x4001:
  - misaligned = 1, stall = 0, bus_valid never asserts, rdata = 0
- Timeout, TIMEOUT_CYC = 4, bus_ready held 0:
  - bus_valid high for 4 cycles then drops, bus_err one-cycle pulse
  - rdata = 0, DONE for 1 cycle, then IDLE
- rst asserted mid-BUSY between clock edges:
  - bus_valid, stall and all outputs go to reset values immediately
  - after release, a fresh request starts a new transaction normally
